// File: rtl/alu_src_b_pkg.sv
// Shared select encoding for the ALU operand-B stage.
package alu_src_b_pkg;

  localparam int SEL_W = 3;

  typedef enum logic [SEL_W-1:0] {
    SEL_REG_B   = 3'd0,
    SEL_INC     = 3'd1,
    SEL_IMM_SE  = 3'd2,
    SEL_MDR     = 3'd3,
    SEL_BR_OFF  = 3'd4,
    SEL_IMM_ZE  = 3'd5,
    SEL_LUI     = 3'd6,
    SEL_ILLEGAL = 3'd7
  } sel_e;

endpackage

// File: rtl/operand_b_decode.sv
// Combinational operand-B select and extend; zero latency, no flow control.
// Code 7 yields zero data and raises err.
module operand_b_decode
  import alu_src_b_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int IMM_W    = 16,
  parameter int PC_INC   = 4,
  parameter int BR_SHIFT = 2
) (
  input  logic [SEL_W-1:0] sel,
  input  logic [WIDTH-1:0] reg_b,
  input  logic [WIDTH-1:0] mdr,
  input  logic [IMM_W-1:0] imm,
  output logic [WIDTH-1:0] data,
  output logic             err
);

  logic [WIDTH-1:0] imm_se;
  logic [WIDTH-1:0] imm_ze;
  logic [WIDTH-1:0] imm_hi;

  assign imm_se = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
  assign imm_ze = {{(WIDTH-IMM_W){1'b0}}, imm};
  assign imm_hi = {imm, {(WIDTH-IMM_W){1'b0}}};

  always_comb begin
    data = '0;
    err  = 1'b0;
    case (sel_e'(sel))
      SEL_REG_B:  data = reg_b;
      SEL_INC:    data = WIDTH'(PC_INC);
      SEL_IMM_SE: data = imm_se;
      SEL_MDR:    data = mdr;
      SEL_BR_OFF: data = imm_se << BR_SHIFT;
      SEL_IMM_ZE: data = imm_ze;
      SEL_LUI:    data = imm_hi;
      default:    err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_src_b_stage.sv
// Registered operand-B stage: 1-cycle latency, valid/ready with a one-entry skid.
// in_ready comes only from skid occupancy, so out_ready never reaches it combinationally.
module alu_src_b_stage
  import alu_src_b_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int IMM_W    = 16,
  parameter int PC_INC   = 4,
  parameter int BR_SHIFT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] sel,
  input  logic [WIDTH-1:0] reg_b,
  input  logic [WIDTH-1:0] mdr,
  input  logic [IMM_W-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  typedef struct packed {
    logic             err;
    logic [WIDTH-1:0] data;
  } opnd_t;

  opnd_t dec;
  opnd_t out_q;
  opnd_t skid_q;
  logic  skid_vld;
  logic  accept;
  logic  consume;

  operand_b_decode #(
    .WIDTH    (WIDTH),
    .IMM_W    (IMM_W),
    .PC_INC   (PC_INC),
    .BR_SHIFT (BR_SHIFT)
  ) u_decode (
    .sel   (sel),
    .reg_b (reg_b),
    .mdr   (mdr),
    .imm   (imm),
    .data  (dec.data),
    .err   (dec.err)
  );

  assign in_ready = ~skid_vld;
  assign accept   = in_valid & in_ready;
  assign consume  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      skid_vld  <= 1'b0;
      skid_q    <= '0;
    end else if (consume) begin
      // skid is only ever full while the output is full, and blocks accept
      if (skid_vld) begin
        out_q    <= skid_q;
        skid_vld <= 1'b0;
        skid_q   <= '0;
      end else if (accept) begin
        out_q <= dec;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!out_valid) begin
        out_q     <= dec;
        out_valid <= 1'b1;
      end else begin
        skid_q   <= dec;
        skid_vld <= 1'b1;
      end
    end
  end

  assign out_data = out_q.data;
  assign out_err  = out_q.err;

endmodule

// File: tb/tb_alu_src_b_stage.sv
// Directed bench for alu_src_b_stage with hand-computed expected operands.
module tb_alu_src_b_stage;

  localparam int WIDTH = 32;
  localparam int IMM_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       sel;
  logic [WIDTH-1:0] reg_b;
  logic [WIDTH-1:0] mdr;
  logic [IMM_W-1:0] imm;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;

  int total  = 0;
  int passed = 0;

  alu_src_b_stage dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .reg_b     (reg_b),
    .mdr       (mdr),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic vld, input logic [WIDTH-1:0] dat,
                         input logic err, input logic rdy);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, vld});
    chk({tag, ".data"},  out_data, dat);
    chk({tag, ".err"},   {31'd0, out_err}, {31'd0, err});
    chk({tag, ".ready"}, {31'd0, in_ready}, {31'd0, rdy});
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; sel = 3'd0;
    reg_b = '0; mdr = '0; imm = '0; out_ready = 1'b0;
    step();
    step();
    chk_out("reset", 1'b0, 32'h0, 1'b0, 1'b1);
    reset = 1'b0;

    // sign-extended immediate, 1-cycle latency
    in_valid = 1'b1; out_ready = 1'b1; sel = 3'd2; imm = 16'hFFFC;
    step();
    chk_out("imm_se", 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);

    sel = 3'd4; imm = 16'h8001;
    step();
    chk_out("br_off", 1'b1, 32'hFFFE_0004, 1'b0, 1'b1);
    sel = 3'd5; imm = 16'h8001;
    step();
    chk_out("imm_ze", 1'b1, 32'h0000_8001, 1'b0, 1'b1);
    sel = 3'd6; imm = 16'h1234;
    step();
    chk_out("lui", 1'b1, 32'h1234_0000, 1'b0, 1'b1);

    sel = 3'd7; reg_b = 32'hDEAD_BEEF;
    step();
    chk_out("illegal", 1'b1, 32'h0, 1'b1, 1'b1);
    sel = 3'd0;
    step();
    chk_out("reg_b", 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
    in_valid = 1'b0;
    step();
    chk("drain.valid", {31'd0, out_valid}, 32'd0);

    // stall: A in output, B in skid
    out_ready = 1'b0; in_valid = 1'b1; sel = 3'd1;
    step();
    chk_out("stall_a", 1'b1, 32'h4, 1'b0, 1'b1);
    sel = 3'd3; mdr = 32'h55;
    step();
    chk_out("stall_b", 1'b1, 32'h4, 1'b0, 1'b0);
    in_valid = 1'b0; mdr = 32'h99; sel = 3'd7;
    step();
    chk_out("stall_hold", 1'b1, 32'h4, 1'b0, 1'b0);
    out_ready = 1'b1;
    step();
    chk_out("drain_b", 1'b1, 32'h55, 1'b0, 1'b1);
    step();
    chk("drain_end.valid", {31'd0, out_valid}, 32'd0);

    // flush with both entries full and a request presented
    out_ready = 1'b0; in_valid = 1'b1; sel = 3'd0; reg_b = 32'h11;
    step();
    reg_b = 32'h22;
    step();
    chk("fill.ready", {31'd0, in_ready}, 32'd0);
    flush = 1'b1; reg_b = 32'h33;
    step();
    chk_out("flush_full", 1'b0, 32'h0, 1'b0, 1'b1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("flush_full_after.valid", {31'd0, out_valid}, 32'd0);

    // flush outranks an accept that in_ready would have allowed
    out_ready = 1'b0; in_valid = 1'b1; reg_b = 32'h44;
    step();
    chk_out("pre_flush", 1'b1, 32'h44, 1'b0, 1'b1);
    flush = 1'b1; reg_b = 32'h66;
    step();
    chk_out("flush_acc", 1'b0, 32'h0, 1'b0, 1'b1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("flush_acc_after.valid", {31'd0, out_valid}, 32'd0);

    // reset during a full stall
    out_ready = 1'b0; in_valid = 1'b1; sel = 3'd3; mdr = 32'hAA;
    step();
    mdr = 32'hBB;
    step();
    chk_out("pre_reset", 1'b1, 32'hAA, 1'b0, 1'b0);
    in_valid = 1'b0; reset = 1'b1;
    step();
    chk_out("stall_reset", 1'b0, 32'h0, 1'b0, 1'b1);
    reset = 1'b0; in_valid = 1'b1; out_ready = 1'b1; sel = 3'd5; imm = 16'h00FF;
    step();
    chk_out("post_reset", 1'b1, 32'h0000_00FF, 1'b0, 1'b1);
    in_valid = 1'b0;
    step();
    chk("post_reset_drain.valid", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
